// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS32 controller, datapath and ALU control decoder.
// moore_ctrl() gives the state-only part of the control word.
`timescale 1ns/1ps
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MADDR  = 4'd3,
    S_MRD    = 4'd4,
    S_MWB    = 4'd5,
    S_MWR    = 4'd6,
    S_REXE   = 4'd7,
    S_RWB    = 4'd8,
    S_IEXE   = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_ERR    = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       err;
  } ctrl_t;

  function automatic ctrl_t moore_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PC_ALU;
      end
      S_DECODE: c.alu_src_b = SRCB_IMM_SH;
      S_MADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MWR: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        c.mem_we  = 1'b1;
      end
      S_MWB: begin
        c.reg_we     = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_REXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        c.reg_we  = 1'b1;
        c.reg_dst = 1'b1;
      end
      S_IEXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_IWB: c.reg_we = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_src = PC_JUMP;
        c.pc_we  = 1'b1;
      end
      S_ERR: c.err = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory-handshake watchdog: counts unacknowledged request cycles and flags when
// the count reaches WAIT_MAX.
`timescale 1ns/1ps
module ctrl_wait_timer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic timeout_o
);

  logic [CNT_W-1:0] cnt_q;

  assign timeout_o = (cnt_q == CNT_W'(WAIT_MAX));

  // Holds at WAIT_MAX so the compare cannot wrap if the FSM is slow to react.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && !timeout_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main sequencing FSM of the multi-cycle MIPS32 datapath with memory req/ack watchdog.
// Moore strobes are registered from the next state; ir_we/pc_we carry the input-qualified terms.
`timescale 1ns/1ps
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       err,
  output logic [3:0] state_dbg
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   timeout;
  logic   fetch_ack;
  logic   unused_funct;

  assign unused_funct = ^funct;
  assign fetch_ack    = (state_q == S_FETCH) && mem_ack;

  ctrl_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!ctrl_q.mem_req || mem_ack),
    .inc_i     (ctrl_q.mem_req && !mem_ack),
    .timeout_o (timeout)
  );

  // An ack in the same cycle as the timeout still completes the access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack)      state_d = S_DECODE;
        else if (timeout) state_d = S_ERR;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_REXE;
          OP_LW, OP_SW:  state_d = S_MADDR;
          OP_ADDI:       state_d = S_IEXE;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_ERR;
        endcase
      end
      S_MADDR: state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
      S_MRD: begin
        if (mem_ack)      state_d = S_MWB;
        else if (timeout) state_d = S_ERR;
      end
      S_MWR: begin
        if (mem_ack)      state_d = S_FETCH;
        else if (timeout) state_d = S_ERR;
      end
      S_REXE:   state_d = S_RWB;
      S_IEXE:   state_d = S_IWB;
      S_MWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= moore_ctrl(state_d);
    end
  end

  assign mem_req    = ctrl_q.mem_req;
  assign mem_we     = ctrl_q.mem_we;
  assign iord       = ctrl_q.iord;
  assign ir_we      = fetch_ack;
  assign pc_we      = ctrl_q.pc_we || fetch_ack || ((state_q == S_BRANCH) && alu_zero);
  assign pc_src     = ctrl_q.pc_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign reg_we     = ctrl_q.reg_we;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign err        = ctrl_q.err;
  assign state_dbg  = state_q;

endmodule
